// File: rtl/f1_sweep_pkg.sv
// f1_sweep_pkg
// Shared types and constants for the four-input exhaustive sweep checker.
//   state_t      : sweep controller state (IDLE, DRIVE, DONE)
//   NUM_VECTORS  : number of input combinations of a four-input function
//   IDX_W        : width of the vector index
//   CNT_W        : width of the mismatch counter (holds 0..16)
package f1_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
// Counts the cycles a stimulus vector has been held and flags the final one.
//   clk     in  : system clock
//   rst_n   in  : asynchronous active-low reset
//   clear   in  : force the count back to 0
//   enable  in  : advance the count this cycle
//   last    out : high while enabled and the count equals DWELL_CYCLES-1
module dwell_counter #(
  parameter int DWELL_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [W-1:0] LAST_CNT = W'(DWELL_CYCLES - 1);

  logic [W-1:0] count_reg;

  assign last = enable && (count_reg == LAST_CNT);

  // Wraps to 0 on the final dwell cycle so the next vector starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear || last) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/f1_sweep_checker.sv
// f1_sweep_checker
// Drives a four-input function through all 16 input vectors in ascending
// order, holding each for DWELL_CYCLES cycles, samples the response on the
// last dwell cycle and compares the assembled truth table with a mask.
//   clk             in  : system clock
//   rst_n           in  : asynchronous active-low reset
//   start           in  : single-cycle sweep request (ignored while busy)
//   expected[15:0]  in  : expected truth table, bit i for {a,b,c,d}==i
//   f1              in  : response of the function under test
//   a,b,c,d         out : registered stimulus, a is the MSB
//   busy            out : sweep in progress
//   done            out : sweep complete, results valid
//   pass            out : captured matches expected (while done)
//   captured[15:0]  out : sampled truth table
//   mismatch_count  out : number of mismatching vectors (0..16)
//   first_fail_idx  out : lowest mismatching vector index, 0 if none
module f1_sweep_checker
  import f1_sweep_pkg::*;
#(
  parameter int DWELL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      expected,
  input  logic             f1,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      captured,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  stim_reg, stim_next;
  logic [15:0]       expected_reg, expected_next;
  logic [15:0]       captured_reg, captured_next;
  logic [CNT_W-1:0]  mismatch_reg, mismatch_next;
  logic [IDX_W-1:0]  first_fail_reg, first_fail_next;
  logic              dwell_clear;
  logic              dwell_last;

  dwell_counter #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (dwell_clear),
    .enable (state_reg == DRIVE),
    .last   (dwell_last)
  );

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    expected_next   = expected_reg;
    captured_next   = captured_reg;
    mismatch_next   = mismatch_reg;
    first_fail_next = first_fail_reg;
    dwell_clear     = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          expected_next   = expected;
          captured_next   = '0;
          mismatch_next   = '0;
          first_fail_next = '0;
          idx_next        = '0;
          dwell_clear     = 1'b1;
          state_next      = DRIVE;
        end
      end
      DRIVE: begin
        if (dwell_last) begin
          captured_next[idx_reg] = f1;
          if (f1 != expected_reg[idx_reg]) begin
            mismatch_next = mismatch_reg + CNT_W'(1);
            // Only the first mismatch of the sweep records its index.
            if (mismatch_reg == '0) begin
              first_fail_next = idx_reg;
            end
          end
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Stimulus is registered from the next index so it changes on the same
    // edge that advances the index, and drops to 0000 outside DRIVE.
    stim_next = (state_next == DRIVE) ? idx_next : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      stim_reg       <= '0;
      expected_reg   <= '0;
      captured_reg   <= '0;
      mismatch_reg   <= '0;
      first_fail_reg <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      stim_reg       <= stim_next;
      expected_reg   <= expected_next;
      captured_reg   <= captured_next;
      mismatch_reg   <= mismatch_next;
      first_fail_reg <= first_fail_next;
    end
  end

  assign {a, b, c, d}   = stim_reg;
  assign busy           = (state_reg == DRIVE);
  assign done           = (state_reg == DONE);
  assign pass           = (state_reg == DONE) && (mismatch_reg == '0);
  assign captured       = captured_reg;
  assign mismatch_count = mismatch_reg;
  assign first_fail_idx = first_fail_reg;

endmodule

// File: tb/tb_f1_sweep_checker.sv
// tb_f1_sweep_checker
// Self-checking bench: a loopback function model answers the stimulus and
// a truth-table reference computes the expected sweep results.
module tb_f1_sweep_checker;

  localparam int D     = 5;
  localparam int SWEEP = 16 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expected = '0;
  logic        f1;
  logic        a, b, c, d;
  logic        busy, done, pass;
  logic [15:0] captured;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;

  logic [15:0] model_mask = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Function under test: a lookup into the current model truth table.
  assign f1 = model_mask[{a, b, c, d}];

  f1_sweep_checker #(
    .DWELL_CYCLES(D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .expected       (expected),
    .f1             (f1),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .captured       (captured),
    .mismatch_count (mismatch_count),
    .first_fail_idx (first_fail_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {a, b, c, d, busy, done, pass, captured, mismatch_count, first_fail_idx}, 32'h0);
  endtask

  // One full sweep. noisy: random start pulses and expected changes during
  // the sweep. start_at_end: start held high on the DONE-entry edge only.
  task automatic run_sweep(input logic [15:0] mask, input logic [15:0] exp_mask,
                           input bit noisy, input bit start_at_end);
    logic [15:0] ref_cap;
    int          ref_mm;
    int          ref_ff;

    ref_cap = mask;
    ref_mm  = 0;
    ref_ff  = 0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i] != exp_mask[i]) begin
        if (ref_mm == 0) ref_ff = i;
        ref_mm++;
      end
    end

    model_mask = mask;
    expected   = exp_mask;
    start      = 1'b1;
    step();
    start      = 1'b0;

    for (int n = 0; n < SWEEP - 1; n++) begin
      check("vector", {28'h0, a, b, c, d}, n / D);
      check("busy_done", {30'h0, busy, done}, 32'h2);
      if (noisy) begin
        start    = ($urandom_range(0, 3) == 0);
        expected = 16'($urandom);
      end
      step();
    end

    start = start_at_end;
    step();
    start = 1'b0;

    check("end_busy_done", {30'h0, busy, done}, 32'h1);
    check("end_stim", {28'h0, a, b, c, d}, 32'h0);
    check("captured", {16'h0, captured}, {16'h0, ref_cap});
    check("mismatch_count", {27'h0, mismatch_count}, ref_mm);
    check("first_fail_idx", {28'h0, first_fail_idx}, ref_ff);
    check("pass", {31'h0, pass}, (ref_mm == 0) ? 32'h1 : 32'h0);

    if (start_at_end) begin
      step();
      check("start_on_done_entry_ignored", {30'h0, busy, done}, 32'h1);
    end

    $display("sweep mask=%04h expected=%04h captured=%04h mismatches=%0d first=%0d pass=%0b",
             mask, exp_mask, captured, mismatch_count, first_fail_idx, pass);
  endtask

  initial begin
    logic [15:0] rmask;
    logic [15:0] flips;

    // Reset held, then released with no start: everything stays at 0.
    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_all_zero("idle_no_start");
    end
    $display("idle: outputs held at zero for 20 cycles");

    // Directed sweeps; the second restarts straight from DONE.
    run_sweep(16'hA5C3, 16'hA5C3, 1'b0, 1'b0);
    run_sweep(16'hA5C3, 16'hA5C2, 1'b1, 1'b0);
    run_sweep(16'h0000, 16'hFFFF, 1'b0, 1'b1);

    // Reset during vector 7 aborts the sweep at once.
    model_mask = 16'hA5C3;
    expected   = 16'hA5C3;
    start      = 1'b1;
    step();
    start      = 1'b0;
    repeat (7 * D + 2) step();
    check("pre_abort_vector", {28'h0, a, b, c, d}, 32'h7);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_async");
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("after_abort");
    $display("abort: reset during vector 7 cleared all outputs");
    run_sweep(16'hA5C3, 16'hA5C3, 1'b0, 1'b0);

    // Randomized truth tables with sparse expected-value disagreements.
    for (int t = 0; t < 5; t++) begin
      rmask = 16'($urandom);
      flips = ($urandom_range(0, 2) == 0) ? 16'h0
            : (16'($urandom) & 16'($urandom) & 16'($urandom));
      run_sweep(rmask, rmask ^ flips, t[0], t[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
